burst_beat_counter: RTL
=======================

// Module: burst_beat_counter
// PURPOSE
// Parametrised beat counter for the AXI4-Lite/burst datapath: counts handshaked beats (i_run) of a burst
// whose length is loaded at burst start, and pulses o_done on the last beat. Supports one-shot and
// auto-reload (wrap) modes, exposes the live beat index, and flags protocol misuse.
// Sits beside the transfer FSM; the FSM starts a burst, qualifies i_run with valid&ready, and consumes o_done.
// PARAMETERS
// CNT_WIDTH   8   width of beat index and length field; bursts of 1..2**CNT_WIDTH beats
// PORTS
// clk         in   1          clock, all logic on posedge
// arst        in   1          asynchronous reset, active-high
// restartn    in   1          synchronous clear, active-low; highest priority after arst
// i_start     in   1          start burst; sampled only in IDLE
// i_len       in   CNT_WIDTH  burst length minus one (AXI LEN semantics), latched on accepted i_start
// i_wrap      in   1          mode, latched on accepted i_start: 1 = auto-reload, 0 = one-shot
// i_run       in   1          one beat transferred this cycle
// o_count     out  CNT_WIDTH  current beat index (beats already counted in this burst)
// o_busy      out  1          1 while in COUNT state
// o_done      out  1          registered 1-cycle pulse, cycle after last beat's i_run
// o_err       out  1          registered 1-cycle pulse on misuse (see below)
// BEHAVIOUR
// - arst=1: state IDLE, o_count=0, len_q=0, wrap_q=0, o_busy=0, o_done=0, o_err=0 (+ status regs = 0)
// - restartn=0 (sync): same values as reset; overrides i_start/i_run in that cycle; no o_done/o_err
// - States: IDLE, COUNT. o_busy = (state==COUNT), registered.
// - IDLE & i_start: len_q<=i_len, wrap_q<=i_wrap, o_count<=0, ->COUNT. i_run in same cycle is ignored
//   (first beat may arrive earliest the cycle after start) and sets o_err next cycle.
// - IDLE & i_run & ~i_start: no count; o_err pulses next cycle.
// - COUNT & i_run & o_count!=len_q: o_count<=o_count+1.
// - COUNT & i_run & o_count==len_q: o_done pulses next cycle; o_count<=0;
//   wrap_q=1 -> stay COUNT (next burst same len_q); wrap_q=0 -> IDLE.
// - COUNT & i_start: ignored (len/mode unchanged), o_err pulses next cycle; i_run same cycle still counts.
// - COUNT & ~i_run: hold. No timeout.
// - i_len=0: 1-beat burst; o_done follows first beat. i_len=all-ones: 2**CNT_WIDTH beats, no overflow
//   since compare precedes increment.
// - Arithmetic: o_count increments in CNT_WIDTH bits; never exceeds len_q.
// - o_done and o_err are never asserted for more than one consecutive cycle per event; both may assert together.
// CONFIGURATION
// - BURST_CNT_STATUS_EN defined: adds output o_bursts [15:0] = completed-burst count (increments with each
//   o_done, saturates at 16'hFFFF, cleared by arst/restartn) and output o_err_sticky (set by any o_err,
//   cleared only by arst/restartn).
// - Not defined: those ports and registers do not exist; all other behaviour identical.
// TESTING
// - Reset: arst=1 mid-burst (o_count=3) -> next edge all outputs 0, o_busy=0; restartn=0 same result synchronously.
// - One-shot: CNT_WIDTH=8, i_len=3, i_wrap=0, start then 4 i_run cycles -> o_count 0,1,2,3, o_done one cycle
//   after 4th beat, o_busy=0 same cycle as o_done.
// - Gapped & wrap: i_len=1, i_wrap=1, i_run pattern 1,0,1,1,0,1 -> o_done after beats 2 and 4, o_busy stays 1.
// - Boundaries: i_len=0 -> o_done after each beat; i_len=8'hFF -> o_done only after 256th beat, o_count wraps to 0.
// - Misuse: i_run in IDLE -> o_err pulse, o_count=0; i_start during COUNT with i_len=7 -> o_err, burst ends at old len.
// - BURST_CNT_STATUS_EN: 3 one-shot bursts -> o_bursts=3; one misuse -> o_err_sticky=1 until restartn=0.

Source files
------------

// File: rtl/burst_beat_counter_if.sv
// rtl/burst_beat_counter_if.sv - beat-counter control/status bundle between transfer FSM and counter
//
// Purpose: groups the burst control inputs and counter status outputs.
//   master modport: transfer FSM side (drives i_*, observes o_*)
//   slave  modport: burst_beat_counter side (observes i_*, drives o_*)
// Signals:
//   i_start  start burst (honoured only while the counter is idle)
//   i_len    burst length minus one, latched on an accepted start
//   i_wrap   1 = auto-reload, 0 = one-shot, latched on an accepted start
//   i_run    one beat transferred this cycle (valid & ready)
//   o_count  beats already counted in the current burst
//   o_busy   counter is in a burst
//   o_done   1-cycle pulse, cycle after the last beat
//   o_err    1-cycle pulse on misuse
//   o_bursts, o_err_sticky  completed-burst count / sticky error (BURST_CNT_STATUS_EN only)
// Optional feature macro: BURST_CNT_STATUS_EN

interface burst_beat_counter_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 i_start;
    logic [CNT_WIDTH-1:0] i_len;
    logic                 i_wrap;
    logic                 i_run;
    logic [CNT_WIDTH-1:0] o_count;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;
`ifdef BURST_CNT_STATUS_EN
    logic [15:0]          o_bursts;
    logic                 o_err_sticky;
`endif

    modport master (
        output i_start, i_len, i_wrap, i_run,
`ifdef BURST_CNT_STATUS_EN
        input  o_bursts, o_err_sticky,
`endif
        input  o_count, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_len, i_wrap, i_run,
`ifdef BURST_CNT_STATUS_EN
        output o_bursts, o_err_sticky,
`endif
        output o_count, o_busy, o_done, o_err
    );
endinterface

// File: rtl/burst_beat_counter.sv
// rtl/burst_beat_counter.sv - burst beat counter with one-shot/auto-reload modes and misuse flag
//
// Purpose: counts handshaked beats of a burst whose length is loaded at burst
// start; pulses o_done the cycle after the last beat and o_err on misuse.
// Ports:
//   clk       clock, posedge
//   arst      asynchronous reset, active-high
//   restartn  synchronous clear, active-low (wins over any bus activity)
//   bus       burst_beat_counter_if.slave (i_start/i_len/i_wrap/i_run in,
//             o_count/o_busy/o_done/o_err out)
// Optional feature macro: BURST_CNT_STATUS_EN adds o_bursts and o_err_sticky.

module burst_beat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 restartn,
    burst_beat_counter_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] len_q,   len_d;
    logic                 wrap_q,  wrap_d;
    logic                 done_q,  done_d;
    logic                 err_q,   err_d;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        wrap_d  = wrap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (!restartn) begin
            state_d = IDLE;
            count_d = '0;
            len_d   = '0;
            wrap_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A beat while idle (including the start cycle itself) is never counted.
                    err_d = bus.i_run;
                    if (bus.i_start) begin
                        len_d   = bus.i_len;
                        wrap_d  = bus.i_wrap;
                        count_d = '0;
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    // Restart attempts mid-burst are flagged but leave len/mode untouched.
                    err_d = bus.i_start;
                    if (bus.i_run) begin
                        // Compare before increment so len = all-ones never overflows.
                        if (count_q == len_q) begin
                            done_d  = 1'b1;
                            count_d = '0;
                            if (!wrap_q) begin
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.o_count = count_q;
    assign bus.o_busy  = (state_q == COUNT);
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;

`ifdef BURST_CNT_STATUS_EN
    logic [15:0] bursts_q, bursts_d;
    logic        sticky_q, sticky_d;

    // Status tracks the pulse it summarises, so it updates on the same edge as o_done/o_err.
    always_comb begin
        bursts_d = bursts_q;
        sticky_d = sticky_q | err_d;
        if (done_d && (bursts_q != 16'hFFFF)) begin
            bursts_d = bursts_q + 16'd1;
        end
        if (!restartn) begin
            bursts_d = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bursts_q <= '0;
            sticky_q <= 1'b0;
        end else begin
            bursts_q <= bursts_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.o_bursts     = bursts_q;
    assign bus.o_err_sticky = sticky_q;
`endif

endmodule
